// File: rtl/dmem_arb_pkg.sv
// Shared encodings and the address helper for the data-RAM arbiter.
package dmem_arb_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_HOST = 2'd2;

  // Byte address to word index; callers truncate to the RAM index width.
  function automatic logic [31:0] word_idx(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/dmem_burst_ctr.sv
// Host burst bookkeeping: latched start index and length, beat counter, last-beat flag.
module dmem_burst_ctr
  import dmem_arb_pkg::*;
#(
  parameter  int AW        = 10,
  parameter  int MAX_BURST = 16,
  localparam int LW        = $clog2(MAX_BURST + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          advance,
  input  logic [AW-1:0] start_idx,
  input  logic [LW-1:0] len,
  output logic [AW-1:0] cur_idx,
  output logic          last
);

  logic [AW-1:0] base_q;
  logic [LW-1:0] beat_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_eff;

  // A zero length still moves one beat; oversize requests clamp to MAX_BURST.
  always_comb begin
    len_eff = len;
    if (len == '0) begin
      len_eff = LW'(1);
    end else if (len > LW'(MAX_BURST)) begin
      len_eff = LW'(MAX_BURST);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      beat_q <= '0;
      len_q  <= '0;
    end else if (load) begin
      base_q <= start_idx;
      beat_q <= '0;
      len_q  <= len_eff;
    end else if (advance) begin
      beat_q <= beat_q + LW'(1);
    end
  end

  // Index arithmetic is AW bits wide, so the address wraps modulo the RAM depth.
  assign cur_idx = base_q + AW'(beat_q);
  assign last    = (beat_q == len_q - LW'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter between the MEM stage and a host burst port.
// Optional host fairness is enabled by defining DMEM_ARB_FAIR_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter  int RAM_DEPTH    = 1024,
  parameter  int MAX_BURST    = 16,
  parameter  int STARVE_LIMIT = 4,
  localparam int AW           = $clog2(RAM_DEPTH),
  localparam int LW           = $clog2(MAX_BURST + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [31:0]   core_addr,
  input  logic [31:0]   core_wdata,
  output logic          core_stall,
  output logic [31:0]   core_rdata,
  output logic          core_rvalid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [31:0]   host_addr,
  input  logic [LW-1:0] host_len,
  input  logic [31:0]   host_wdata,
  output logic          host_beat,
  output logic [31:0]   host_rdata,
  output logic          host_rvalid,
  output logic          host_busy,
  output logic          host_done,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  logic [1:0]    state_q, state_d;
  logic [1:0]    owner;
  logic          host_we_q;
  logic          host_forced;
  logic          core_gnt, host_gnt;
  logic          last_beat;
  logic [AW-1:0] core_idx, host_start_idx, burst_idx;

  assign core_idx       = AW'(word_idx(core_addr));
  assign host_start_idx = AW'(word_idx(host_addr));

  dmem_burst_ctr #(.AW(AW), .MAX_BURST(MAX_BURST)) u_burst_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (host_gnt),
    .advance   (host_beat),
    .start_idx (host_start_idx),
    .len       (host_len),
    .cur_idx   (burst_idx),
    .last      (last_beat)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  // Nothing is granted while reset is high, so a beat in flight cannot write the RAM.
  always_comb begin
    state_d   = state_q;
    core_gnt  = 1'b0;
    host_gnt  = 1'b0;
    host_beat = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          host_gnt = host_req & (~core_req | host_forced);
          core_gnt = core_req & ~host_gnt;
          if (host_gnt) state_d = S_BURST;
        end
        S_BURST: begin
          host_beat = 1'b1;
          if (last_beat) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    owner = OWN_NONE;
    if (host_beat)     owner = OWN_HOST;
    else if (core_gnt) owner = OWN_CORE;
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (owner)
      OWN_CORE: begin
        ram_en    = 1'b1;
        ram_we    = core_we;
        ram_addr  = core_idx;
        ram_wdata = core_wdata;
      end
      OWN_HOST: begin
        ram_en    = 1'b1;
        ram_we    = host_we_q;
        ram_addr  = burst_idx;
        ram_wdata = host_wdata;
      end
      default: ;
    endcase
  end

  // NOTE: only control flops are reset; the RAM array itself is never cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      host_we_q   <= 1'b0;
      core_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (host_gnt) host_we_q <= host_we;
      core_rvalid <= core_gnt & ~core_we;
      host_rvalid <= host_beat & ~host_we_q;
    end
  end

`ifdef DMEM_ARB_FAIR_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q;

  assign host_forced = (starve_q == SW'(STARVE_LIMIT));

  // Counts core wins over a waiting host; any host grant or a dropped request restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else if (!host_req || host_gnt) begin
      starve_q <= '0;
    end else if (core_gnt && !host_forced) begin
      starve_q <= starve_q + SW'(1);
    end
  end
`else
  assign host_forced = 1'b0;
`endif

  assign core_stall = ~reset & core_req & ~core_gnt;
  assign host_busy  = ~reset & ((state_q == S_BURST) | (state_q == S_DONE));
  assign host_done  = ~reset & (state_q == S_DONE);
  assign core_rdata = core_rvalid ? ram_rdata : '0;
  assign host_rdata = host_rvalid ? ram_rdata : '0;

endmodule
